pipeline_broadcast: RTL

PIPELINE_BROADCAST -- requirements
Module: PipelineBroadcast

---
 rtl/pipeline_broadcast.sv | 83 ++++++++
 1 files changed

// File: rtl/pipeline_broadcast.sv
// One-to-N broadcast stage: each upstream beat is delivered exactly once to every
// channel selected by its mask, either combinationally (REG=0) or through a one-entry buffer (REG=1).
module pipeline_broadcast #(
  parameter int N   = 2,
  parameter int W   = 8,
  parameter int REG = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic [W-1:0] i_data,
  input  logic [N-1:0] i_mask,
  output logic [N-1:0] o_valid,
  input  logic [N-1:0] o_ready,
  output logic [W-1:0] o_data,
  output logic         o_busy
);

  // Handshake semantics: a beat moves across a boundary on the rising edge where valid
  // and ready are both high; valid never waits for ready, and an asserted valid keeps its
  // payload until that edge.

  generate
    if (REG == 0) begin : g_comb
      logic [N-1:0] sent_q;
      logic [N-1:0] sent_d;
      logic         hs;

      // sent records the channels that already took the current upstream beat.
      always_comb begin
        o_valid = '0;
        i_ready = 1'b0;
        o_busy  = 1'b0;
        if (!rst) begin
          o_valid = {N{i_valid}} & i_mask & ~sent_q;
          i_ready = &(o_ready | sent_q | ~i_mask);
          o_busy  = i_valid && (|(i_mask & ~sent_q));
        end
        o_data = i_data;
        hs     = i_valid && i_ready;
        sent_d = hs ? '0 : (sent_q | (o_valid & o_ready));
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) sent_q <= '0;
        else     sent_q <= sent_d;
      end
    end else begin : g_reg
      logic [N-1:0] buf_mask_q;
      logic [N-1:0] buf_mask_d;
      logic [W-1:0] buf_data_q;
      logic [W-1:0] buf_data_d;
      logic         hs;

      // Accept when every channel still owed is taking the beat this cycle.
      always_comb begin
        i_ready    = !rst && ((buf_mask_q & ~o_ready) == '0);
        hs         = i_valid && i_ready;
        buf_mask_d = buf_mask_q & ~o_ready;
        buf_data_d = buf_data_q;
        if (hs) begin
          buf_mask_d = i_mask;
          buf_data_d = i_data;
        end
        o_valid = buf_mask_q;
        o_data  = buf_data_q;
        o_busy  = |buf_mask_q;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          buf_mask_q <= '0;
          buf_data_q <= '0;
        end else begin
          buf_mask_q <= buf_mask_d;
          buf_data_q <= buf_data_d;
        end
      end
    end
  endgenerate

endmodule
